// File: rtl/fp_add_pkg.sv
// Shared constants for the FP32 adder datapath: FSM encoding, mantissa word
// geometry and IEEE-754 single-precision special values.
package fp_add_pkg;

  localparam int MANT_W      = 49;
  localparam int HIDDEN_POS  = 47;
  localparam int GUARD_POS   = 23;
  localparam int COARSE_STEP = 8;

  // Exponent carried with two spare bits so +1 steps past 254 stay visible
  localparam int EXP_W = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [7:0]  EXP_INF  = 8'hFF;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even of a normalized magnitude and packing into an FP32
// word, with zero / inexact / overflow flags. Purely combinational.
module fp_round_pack
  import fp_add_pkg::*;
(
  input  logic                sign,
  input  logic                is_zero,
  input  logic [EXP_W-1:0]    exp,
  input  logic [HIDDEN_POS:0] mag,
  output logic [31:0]         result,
  output logic                flag_zero,
  output logic                flag_inexact,
  output logic                flag_overflow
);

  logic              lsb;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [24:0]       rounded;
  logic [EXP_W-1:0]  exp_field;

  // A denormal (hidden bit clear) that rounds into bit 23 picks up exponent 1
  // straight from the rounded mantissa.
  always_comb begin
    lsb      = mag[GUARD_POS+1];
    guard    = mag[GUARD_POS];
    sticky   = |mag[GUARD_POS-1:0];
    round_up = guard && (sticky || lsb);
    rounded  = {1'b0, mag[HIDDEN_POS:GUARD_POS+1]} + 25'(round_up);

    if (mag[HIDDEN_POS])
      exp_field = exp + EXP_W'(rounded[24]);
    else
      exp_field = EXP_W'(rounded[23]);

    result        = {sign, exp_field[7:0], rounded[22:0]};
    flag_zero     = 1'b0;
    flag_inexact  = guard | sticky;
    flag_overflow = 1'b0;

    if (is_zero) begin
      result    = POS_ZERO;
      flag_zero = 1'b1;
    end else if (exp_field >= EXP_W'(EXP_INF)) begin
      result        = {sign, EXP_INF, 23'h0};
      flag_overflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp_sum_normalizer.sv
// FP32 adder back end: sums the two prepared mantissa words, normalizes over
// several cycles, rounds and packs, with valid/ready on both sides.
module fp_sum_normalizer #(
  parameter int COARSE_STEP = 8,
  parameter int MANT_W      = 49
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] op_1_f_pr,
  input  logic [MANT_W-1:0] op_2_f_pr,
  input  logic [7:0]        exp_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              flag_zero,
  output logic              flag_inexact,
  output logic              flag_overflow
);
  import fp_add_pkg::*;

  logic [1:0]        state;
  logic              sign;
  logic              zero;
  logic [MANT_W-1:0] mag;
  logic [EXP_W-1:0]  exp;

  logic [MANT_W:0]   sum;
  logic [MANT_W:0]   neg_sum;
  logic [MANT_W-1:0] sum_mag;

  logic [31:0]       rp_result;
  logic              rp_zero;
  logic              rp_inexact;
  logic              rp_overflow;

  // Operand magnitudes stay below 2^48, so |sum| always fits the 49-bit word.
  always_comb begin
    sum     = {op_1_f_pr[MANT_W-1], op_1_f_pr} + {op_2_f_pr[MANT_W-1], op_2_f_pr};
    neg_sum = -sum;
    sum_mag = sum[MANT_W] ? neg_sum[MANT_W-1:0] : sum[MANT_W-1:0];
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);

  fp_round_pack u_round_pack (
    .sign          (sign),
    .is_zero       (zero),
    .exp           (exp),
    .mag           (mag[HIDDEN_POS:0]),
    .result        (rp_result),
    .flag_zero     (rp_zero),
    .flag_inexact  (rp_inexact),
    .flag_overflow (rp_overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sign          <= 1'b0;
      zero          <= 1'b0;
      mag           <= '0;
      exp           <= '0;
      result        <= '0;
      flag_zero     <= 1'b0;
      flag_inexact  <= 1'b0;
      flag_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign  <= sum[MANT_W];
            zero  <= 1'b0;
            mag   <= sum_mag;
            exp   <= {2'b00, exp_max};
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          // Carry right-shift folds the lost bit into bit 0 so rounding still sees it.
          if (mag == '0) begin
            zero  <= 1'b1;
            state <= ST_ROUND;
          end else if (mag[MANT_W-1]) begin
            mag   <= {1'b0, mag[MANT_W-1:2], mag[1] | mag[0]};
            exp   <= exp + EXP_W'(1);
            state <= ST_ROUND;
          end else if (mag[HIDDEN_POS]) begin
            state <= ST_ROUND;
          end else if (exp == EXP_W'(1)) begin
            state <= ST_ROUND;
          end else if (mag[HIDDEN_POS -: COARSE_STEP] == '0 &&
                       exp > EXP_W'(COARSE_STEP)) begin
            mag <= mag << COARSE_STEP;
            exp <= exp - EXP_W'(COARSE_STEP);
          end else begin
            mag <= mag << 1;
            exp <= exp - EXP_W'(1);
          end
        end
        ST_ROUND: begin
          result        <= rp_result;
          flag_zero     <= rp_zero;
          flag_inexact  <= rp_inexact;
          flag_overflow <= rp_overflow;
          state         <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_sum_normalizer.md
Name: fp_sum_normalizer

Overview:
Stage directly downstream of the mantissa preparer in the FP32 adder datapath. Accepts the two aligned, sign-applied 49-bit mantissa words plus the larger operand's exponent, then adds them and takes the magnitude. It normalizes iteratively over several cycles, rounds to nearest-even and packs an IEEE-754 single result. Uses a valid/ready handshake on both sides so the iterative normalizer can stall the preparer.

Parameters:
COARSE_STEP, 8, left-shift distance of one coarse normalization step (bits)
MANT_W, 49, prepared mantissa word width (fixed by upstream format)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream presents an operand pair
in_ready  out  1  block can accept (high only in IDLE)
op_1_f_pr  in  49  prepared operand 1, two's complement
op_2_f_pr  in  49  prepared operand 2, two's complement
exp_max  in  8  effective exponent of larger operand, 1..254 (denormals supplied as 1)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  32  packed FP32 sum
flag_zero  out  1  result is ±0
flag_inexact  out  1  guard or sticky bit was nonzero
flag_overflow  out  1  result rounded to infinity

Behaviour:
- Input word format: bit48 sign extension, bit47 hidden bit, bits46:24 fraction, bits23:0 bits shifted out by alignment. Inf/NaN never reach this block; they are bypassed upstream.
- Reset, which takes effect on any cycle and aborts an in-flight operation: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, internal mantissa/exponent registers 0.
- FSM states: IDLE, NORM, ROUND, OUT.
- IDLE: on in_valid&&in_ready, register a 50-bit sign-extended sum. Store sign=sum[49], mag=|sum| as 49 bits, with bit48 able to hold the carry. Store exp=exp_max. Next state NORM.
- NORM, evaluated in priority order each cycle:
  - mag==0: set zero, go to ROUND.
  - mag[48]=1: mag>>=1 with the shifted-out bit ORed into bit0 (sticky); exp+=1; go to ROUND.
  - mag[47]=1: go to ROUND.
  - exp==1: denormal result, no more shifting; go to ROUND.
  - mag[47:40]==0 and exp>COARSE_STEP: mag<<=8, exp-=8; stay in NORM.
  - Otherwise: mag<<=1, exp-=1; stay in NORM.
- ROUND, one cycle:
  - lsb=mag[24], guard=mag[23], sticky=|mag[22:0]. Round up when guard&&(sticky||lsb).
  - mant24=mag[47:24]+roundup. If the 24-bit mantissa overflows, set mantissa to 0x800000 and exp+=1.
  - Exponent field = mag[47] ? exp : 0, which gives a denormal; a denormal rounding up into bit23 becomes exp 1 naturally.
  - exp>=255: result={sign,8'hFF,23'h0}, flag_overflow=1.
  - Zero: result=0x00000000 (+0), flag_zero=1.
  - flag_inexact=guard|sticky.
  - Register result and flags; next state OUT.
- OUT: out_valid=1, result and flags held stable. When out_ready=1, go to IDLE; in_ready rises the next cycle. No new acceptance in the same cycle.
- Latency: accept at cycle T; out_valid at T+3+k, where k = number of NORM shift cycles that stay in NORM. Worst case k≈8.
- Single outstanding operation; throughput one result per 4+k cycles.

Decomposition:
- Package fp_add_pkg: state encoding, MANT_W/HIDDEN_POS=47/GUARD_POS=23, FP32 constants (EXP_INF=8'hFF, POS_ZERO, QNAN).
- One combinational sub-module fp_round_pack: takes sign, exp, mag; returns result and flags. It is instantiated in the ROUND state.

Test Plan:
- 1.0+1.0: op1=op2=0x0_8000_0000_0000, exp_max=127 -> result 0x40000000, flags 0, out_valid at T+3.
- 1.0+(-0.75): op1=0x0_8000_0000_0000, op2=0x1_A000_0000_0000, exp_max=127 -> two 1-bit shifts, result 0x3E800000, out_valid at T+5, inexact=0.
- Cancellation x+(-x): op1=0x0_C000_0000_0000, op2=0x1_4000_0000_0000 -> result 0x00000000, flag_zero=1, out_valid at T+3.
- Tie to even: op1=0x0_8000_0000_0000, op2=0x0_0000_0080_0000, exp_max=127 -> result 0x3F800000, flag_inexact=1. Then op2=0x0_0000_0180_0000 -> result 0x3F800002, flag_inexact=1.
- Overflow: op1=op2=0x0_FFFF_FF00_0000, exp_max=254 -> result 0x7F800000, flag_overflow=1.
- Backpressure/reset: hold out_ready=0 for 5 cycles -> result stable, in_ready=0. Assert rst during NORM -> next cycle IDLE, out_valid=0, in_ready=1.
